// File: rtl/buzzer_sequencer_if.sv
// ROM read port between the buzzer sequencer (master) and the music ROM (slave).
interface buzzer_sequencer_if #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 12
);
  logic                  rom_en_o;
  logic [ADDR_WIDTH-1:0] rom_addr_o;
  logic [DATA_WIDTH-1:0] rom_data_i;

  modport master (output rom_en_o, output rom_addr_o, input rom_data_i);
  modport slave  (input rom_en_o, input rom_addr_o, output rom_data_i);
endinterface

// File: rtl/buzzer_sequencer.sv
// Walks the music ROM word by word and drives the buzzer with a square wave
// of the encoded half-period for the encoded duration.
module buzzer_sequencer #(
  parameter int ADDR_WIDTH    = 16,
  parameter int DATA_WIDTH    = 12,
  parameter int TONE_PRESCALE = 250,
  parameter int BEAT_LEN      = 5000000,
  parameter int LOOP          = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               play_i,
  input  logic               restart_i,
  buzzer_sequencer_if.master rom,
  output logic               buzzer_o,
  output logic               busy_o,
  output logic               done_o
);
  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_LATCH, S_PLAY, S_DONE} state_t;

  localparam int PW = (TONE_PRESCALE > 1) ? $clog2(TONE_PRESCALE) : 1;
  localparam int BW = $clog2(15 * BEAT_LEN + 1);

  state_t                r_state;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic                  r_en, r_buzz, r_busy, r_done, r_tone;
  logic [7:0]            r_per, r_step;
  logic [PW-1:0]         r_pre;
  logic [BW-1:0]         r_beat, r_lim;

  logic [3:0] w_dur;
  logic [7:0] w_per;
  logic       w_pre_wrap, w_step_wrap, w_note_end;

  assign w_dur       = rom.rom_data_i[11:8];
  assign w_per       = rom.rom_data_i[7:0];
  assign w_pre_wrap  = (r_pre == PW'(TONE_PRESCALE - 1));
  assign w_step_wrap = (r_step == r_per - 8'd1);
  assign w_note_end  = (r_beat == r_lim - BW'(1));

  assign rom.rom_en_o   = r_en;
  assign rom.rom_addr_o = r_addr;
  assign buzzer_o       = r_buzz;
  assign busy_o         = r_busy;
  assign done_o         = r_done;

  always_ff @(posedge clk) begin
    if (rst || restart_i) begin
      r_state <= S_IDLE;
      r_addr  <= '0;
      r_en    <= 1'b0;
      r_buzz  <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_tone  <= 1'b0;
      r_per   <= '0;
      r_step  <= '0;
      r_pre   <= '0;
      r_beat  <= '0;
      r_lim   <= '0;
    end else begin
      r_en   <= 1'b0;
      r_done <= 1'b0;
      r_buzz <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (play_i) begin
            r_state <= S_FETCH;
            r_en    <= 1'b1;
            r_busy  <= 1'b1;
          end
        end
        S_FETCH: r_state <= S_LATCH;
        S_LATCH: begin
          if (w_dur == 4'd0) begin
            r_done <= 1'b1;
            if (LOOP != 0) begin
              r_addr  <= '0;
              r_state <= S_FETCH;
              r_en    <= 1'b1;
            end else begin
              r_state <= S_DONE;
              r_busy  <= 1'b0;
            end
          end else begin
            r_per   <= w_per;
            r_lim   <= BW'(w_dur) * BW'(BEAT_LEN);
            r_pre   <= '0;
            r_step  <= '0;
            r_beat  <= '0;
            r_tone  <= 1'b0;
            r_state <= S_PLAY;
          end
        end
        S_PLAY: begin
          // Everything freezes while paused; buzzer is forced low.
          if (play_i) begin
            r_beat <= r_beat + BW'(1);
            if (w_pre_wrap) begin
              r_pre <= '0;
              if (w_step_wrap) begin
                r_step <= '0;
                r_tone <= ~r_tone;
              end else begin
                r_step <= r_step + 8'd1;
              end
            end else begin
              r_pre <= r_pre + PW'(1);
            end
            // Leaving PLAY keeps the buzzer low through FETCH/LATCH.
            if (w_note_end) begin
              r_addr  <= r_addr + ADDR_WIDTH'(1);
              r_state <= S_FETCH;
              r_en    <= 1'b1;
            end else begin
              r_buzz <= r_tone && (r_per != 8'd0);
            end
          end
        end
        S_DONE:  r_state <= S_DONE;
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_buzzer_sequencer.sv
// Two sequencers (looping 16-bit, non-looping 3-bit address) run side by side
// against a cycle-level reference model that derives tone phase arithmetically.
module tb_buzzer_sequencer;
  localparam int TP = 2, BL = 20;
  localparam int P_IDLE = 0, P_FETCH = 1, P_LATCH = 2, P_PLAY = 3, P_DONE = 4;

  logic clk = 1'b0;
  logic rst, play, restart;
  logic buz_a, busy_a, done_a, buz_b, busy_b, done_b;
  int   n_assert = 0, n_fail = 0;

  buzzer_sequencer_if #(.ADDR_WIDTH(16), .DATA_WIDTH(12)) ifa ();
  buzzer_sequencer_if #(.ADDR_WIDTH(3),  .DATA_WIDTH(12)) ifb ();

  buzzer_sequencer #(.ADDR_WIDTH(16), .DATA_WIDTH(12), .TONE_PRESCALE(TP),
                     .BEAT_LEN(BL), .LOOP(1)) dut_a (
    .clk(clk), .rst(rst), .play_i(play), .restart_i(restart), .rom(ifa.master),
    .buzzer_o(buz_a), .busy_o(busy_a), .done_o(done_a));

  buzzer_sequencer #(.ADDR_WIDTH(3), .DATA_WIDTH(12), .TONE_PRESCALE(TP),
                     .BEAT_LEN(BL), .LOOP(0)) dut_b (
    .clk(clk), .rst(rst), .play_i(play), .restart_i(restart), .rom(ifb.master),
    .buzzer_o(buz_b), .busy_o(busy_b), .done_o(done_b));

  always #5 clk = ~clk;

  logic [11:0] rom [16];

  // Instance 0 sees an end marker beyond the 16-entry image; instance 1 aliases mod 8.
  function automatic logic [11:0] rom_rd(input int k, input int a);
    if (k == 1) return rom[4'(a % 8)];
    if (a < 16) return rom[4'(a)];
    return 12'h000;
  endfunction

  always @(posedge clk) if (ifa.rom_en_o) ifa.rom_data_i <= rom_rd(0, int'(ifa.rom_addr_o));
  always @(posedge clk) if (ifb.rom_en_o) ifb.rom_data_i <= rom_rd(1, int'(ifb.rom_addr_o));

  int m_ph[2], m_addr[2], m_dur[2], m_per[2], m_act[2];
  bit m_en[2], m_buzz[2], m_done[2];
  int aw[2] = '{16, 3};
  bit lp[2] = '{1'b1, 1'b0};

  task automatic mstep(input int k);
    logic [11:0] w;
    bit nb;
    m_en[k] = 0; m_done[k] = 0; m_buzz[k] = 0;
    if (rst || restart) begin
      m_ph[k] = P_IDLE; m_addr[k] = 0;
    end else begin
      case (m_ph[k])
        P_IDLE: if (play) begin m_ph[k] = P_FETCH; m_en[k] = 1; end
        P_FETCH: m_ph[k] = P_LATCH;
        P_LATCH: begin
          w = rom_rd(k, m_addr[k]);
          if (w[11:8] == 4'd0) begin
            m_done[k] = 1;
            if (lp[k]) begin m_addr[k] = 0; m_ph[k] = P_FETCH; m_en[k] = 1; end
            else m_ph[k] = P_DONE;
          end else begin
            m_dur[k] = int'(w[11:8]); m_per[k] = int'(w[7:0]);
            m_act[k] = 0; m_ph[k] = P_PLAY;
          end
        end
        P_PLAY: if (play) begin
          nb = 0;
          if (m_per[k] != 0) nb = ((m_act[k] / (m_per[k] * TP)) % 2) == 1;
          m_act[k]++;
          if (m_act[k] == m_dur[k] * BL) begin
            m_addr[k] = (m_addr[k] + 1) % (1 << aw[k]);
            m_ph[k] = P_FETCH; m_en[k] = 1;
          end else begin
            m_buzz[k] = nb;
          end
        end
        default: ;
      endcase
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s t=%0t observed=%0h expected=%0h", tag, $time, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("a_rom_en",   32'(ifa.rom_en_o),   32'(m_en[0]));
    chk("a_rom_addr", 32'(ifa.rom_addr_o), m_addr[0]);
    chk("a_buzzer",   32'(buz_a),          32'(m_buzz[0]));
    chk("a_busy",     32'(busy_a),         32'(m_ph[0] >= P_FETCH && m_ph[0] <= P_PLAY));
    chk("a_done",     32'(done_a),         32'(m_done[0]));
    chk("b_rom_en",   32'(ifb.rom_en_o),   32'(m_en[1]));
    chk("b_rom_addr", 32'(ifb.rom_addr_o), m_addr[1]);
    chk("b_buzzer",   32'(buz_b),          32'(m_buzz[1]));
    chk("b_busy",     32'(busy_b),         32'(m_ph[1] >= P_FETCH && m_ph[1] <= P_PLAY));
    chk("b_done",     32'(done_b),         32'(m_done[1]));
  endtask

  task automatic tick();
    @(posedge clk);
    mstep(0); mstep(1);
    @(negedge clk);
    check_all();
  endtask

  task automatic rand_image(input int n_notes);
    for (int i = 0; i < 16; i++) rom[i] = 12'h000;
    for (int i = 0; i < n_notes; i++)
      rom[i] = {4'($urandom_range(1, 2)), 8'($urandom_range(0, 4))};
  endtask

  task automatic rand_run(input int cycles);
    for (int c = 0; c < cycles; c++) begin
      if ($urandom_range(0, 19) == 0) play = ~play;
      restart = ($urandom_range(0, 299) == 0);
      rst     = ($urandom_range(0, 599) == 0);
      tick();
    end
    restart = 0; rst = 0;
  endtask

  initial begin
    rst = 1; play = 0; restart = 0;
    for (int i = 0; i < 16; i++) rom[i] = 12'h000;
    rom[0] = 12'h203; rom[1] = 12'h100; rom[2] = 12'h000;
    repeat (3) tick();

    // Tone, rest, end marker: A loops back to 0, B parks in DONE.
    rst = 0; play = 1;
    repeat (150) tick();

    // Pause for 10 cycles in the middle of note 0x203.
    restart = 1; tick(); restart = 0;
    repeat (3 + 15) tick();
    play = 0; repeat (10) tick();
    play = 1; repeat (60) tick();

    // restart_i mid-note, then rst mid-note with play held low for a while.
    restart = 1; tick(); restart = 0;
    repeat (10) tick();
    restart = 1; tick(); restart = 0;
    repeat (12) tick();
    rst = 1; tick(); rst = 0; play = 0;
    repeat (6) tick();
    play = 1; repeat (40) tick();

    // Eight notes with no marker: B's 3-bit address wraps 7 -> 0.
    rst = 1; rand_image(8); repeat (2) tick(); rst = 0; play = 1;
    rand_run(2500);

    // Marker in the middle of the song.
    rst = 1; rand_image(8); rom[5] = 12'h000; repeat (2) tick(); rst = 0; play = 1;
    rand_run(1500);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/buzzer_sequencer.md
Name: buzzer_sequencer

Overview:
Music sequencer that sits directly downstream of the buzzer music block ROM. It generates the ROM read address and enable, decodes each 12-bit note word, and drives the buzzer pin with a square wave for the encoded duration. It then advances to the next word. Control comes from game logic through play, restart and done signals.

Parameters:
ADDR_WIDTH, 16, ROM address width; must match the ROM.
DATA_WIDTH, 12, ROM word width; fixed at 12 for the word format below.
TONE_PRESCALE, 250, clk cycles per tone step (>=1).
BEAT_LEN, 5000000, clk cycles per duration unit (>=1).
LOOP, 1, 1 = restart at address 0 after the end marker; 0 = stop.

Ports:
clk  input  1  system clock, single domain
rst  input  1  synchronous active-high reset
play_i  input  1  level; 1 = play, 0 = pause
restart_i  input  1  one-cycle pulse; rewind to address 0
rom_en_o  output  1  ROM read enable
rom_addr_o  output  ADDR_WIDTH  ROM read address
rom_data_i  input  DATA_WIDTH  ROM read data; valid 1 cycle after rom_en_o
buzzer_o  output  1  square wave to the buzzer
busy_o  output  1  1 while a song is in progress (not IDLE/DONE)
done_o  output  1  one-cycle pulse when the end marker is read

Behaviour:
- Reset: all outputs 0, address 0, counters 0, state IDLE. rst is synchronous active-high and overrides everything.
- Word format:
  - [11:8] dur = duration in BEAT_LEN units.
  - [7:0] per = half-period in TONE_PRESCALE steps.
  - dur==0 is the end marker; per is ignored.
  - per==0 with dur!=0 is a rest.
- States: IDLE, FETCH, LATCH, PLAY, DONE.
- IDLE: when play_i==1, go to FETCH.
- FETCH (1 cycle): rom_en_o=1, rom_addr_o=addr; go to LATCH.
  - rom_en_o is high only in FETCH.
  - rom_addr_o holds its value in all other states.
- LATCH (1 cycle): capture rom_data_i.
  - If dur==0: pulse done_o for exactly 1 cycle. With LOOP=1, set addr=0 and go to FETCH. With LOOP=0, go to DONE.
  - Otherwise: clear the tone and beat counters, set tone flop=0, go to PLAY.
- PLAY, while play_i==1:
  - Prescale counter runs 0..TONE_PRESCALE-1. On each wrap, the step counter increments.
  - When the step counter reaches per-1 on a wrap, toggle the tone flop and clear the step counter. The tone flop therefore toggles every per*TONE_PRESCALE cycles.
  - The beat counter counts the PLAY cycles. After exactly dur*BEAT_LEN active cycles: addr<=addr+1 (modulo 2^ADDR_WIDTH, wraps to 0), go to FETCH.
- PLAY, while play_i==0 (pause): all counters and the tone flop freeze. Counting resumes from the same values when play_i returns to 1.
  - Pause is sampled only in IDLE and PLAY; FETCH and LATCH always complete.
- buzzer_o = registered (tone flop & state==PLAY & play_i & per!=0).
  - buzzer_o is low during FETCH, LATCH, rests, pause, IDLE and DONE.
  - One cycle of register latency relative to the tone flop.
- DONE: busy_o=0, buzzer_o=0. The block stays in DONE until restart_i or rst.
- restart_i, in any state, takes effect next cycle:
  - addr=0, counters cleared, tone flop=0, done_o not asserted, state=IDLE.
  - From IDLE, playback re-fetches at address 0 if play_i==1.
  - restart_i and an end-marker LATCH in the same cycle: restart wins, no done_o pulse.
- busy_o=1 in FETCH, LATCH and PLAY, including while paused.
- Note-to-note gap: 2 cycles (FETCH, LATCH), during which buzzer_o=0.

Test Plan:
Unless stated, TONE_PRESCALE=2, BEAT_LEN=20, ROM model with 1-cycle read latency.
1. ROM[0]=0x203, play_i=1 after reset.
   -> rom_en_o pulses with addr 0.
   -> PLAY lasts 40 cycles; buzzer_o toggles every 6 cycles, starting low.
   -> Next rom_en_o with addr 1 on the cycle after PLAY ends.
2. ROM[1]=0x100 (rest).
   -> buzzer_o stays 0 for 20 cycles; addr advances to 2.
3. ROM[2]=0x000 with LOOP=0.
   -> done_o high exactly 1 cycle; busy_o falls to 0.
   -> No further rom_en_o; buzzer_o=0 until restart_i.
4. Same ROM with LOOP=1.
   -> done_o pulses; the next FETCH uses addr 0; busy_o stays 1 throughout.
5. Pause: play_i low for 10 cycles at cycle 15 of note 0x203.
   -> buzzer_o=0 during the pause.
   -> Note ends 50 cycles after PLAY entry.
   -> Toggle phase continues from its frozen value.
6. Disruption mid-note:
   -> restart_i at PLAY cycle 7: next cycle state IDLE; then FETCH at addr 0.
   -> rst at PLAY cycle 7: all outputs 0 next cycle, and the block stays in IDLE only while play_i is 0.
   -> ROM model at addr 0xFFFF with 0x101 under ADDR_WIDTH=16: after the note, FETCH uses addr 0x0000.
